// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring, on magnitudes)
// with HI/LO result registers; one iteration per clock, WIDTH iterations per op.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic                is_mul, sign_q, sign_r;
    logic [WIDTH-1:0]    mcand, dvs, rem, quo;
    logic [2*WIDTH:0]    prod;
    logic                accept;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (mult_start) begin
                    accept    = 1'b1;
                    state_nxt = MULT;
                end else if (div_start) begin
                    accept    = 1'b1;
                    state_nxt = (op_b == '0) ? FINISH : DIV;
                end
            end
            MULT:    if (cnt == LAST) state_nxt = FINISH;
            DIV:     if (cnt == LAST) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Booth add is done one bit wider than the upper half so that
    // subtracting -2^(W-1) cannot overflow; the extra bit is shifted in.
    logic [WIDTH:0]   upper_ext, mcand_ext, booth_sum;
    always_comb begin
        upper_ext = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
        mcand_ext = {mcand[WIDTH-1], mcand};
        case (prod[1:0])
            2'b01:   booth_sum = upper_ext + mcand_ext;
            2'b10:   booth_sum = upper_ext - mcand_ext;
            default: booth_sum = upper_ext;
        endcase
    end

    logic [WIDTH:0]   div_sh;
    logic [WIDTH+1:0] div_diff;
    assign div_sh   = {rem, quo[WIDTH-1]};
    assign div_diff = {1'b0, div_sh} - {2'b00, dvs};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            cnt         <= '0;
            is_mul      <= 1'b0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            mcand       <= '0;
            dvs         <= '0;
            rem         <= '0;
            quo         <= '0;
            prod        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    busy        <= 1'b1;
                    cnt         <= '0;
                    is_mul      <= mult_start;
                    div_by_zero <= !mult_start && (op_b == '0);
                    mcand       <= op_a;
                    prod        <= {{WIDTH{1'b0}}, op_b, 1'b0};
                    dvs         <= mag(op_b);
                    quo         <= mag(op_a);
                    rem         <= '0;
                    sign_q      <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    sign_r      <= op_a[WIDTH-1];
                end
                MULT: begin
                    prod <= {booth_sum, prod[WIDTH:1]};
                    cnt  <= cnt + CW'(1);
                end
                DIV: begin
                    if (!div_diff[WIDTH+1]) begin
                        rem <= div_diff[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= div_sh[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                end
                FINISH: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (is_mul) begin
                        hi <= prod[2*WIDTH:WIDTH+1];
                        lo <= prod[WIDTH:1];
                    end else if (!div_by_zero) begin
                        // remainder follows dividend sign, quotient truncates to zero
                        hi <= sign_r ? -rem : rem;
                        lo <= sign_q ? -quo : quo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized + directed bench for mult_div_unit against a plain-arithmetic model.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mult_start = 1'b0, div_start = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int          n_tests = 0, n_fail = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;
    logic        exp_dbz = 1'b0;
    int          exp_lat = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .mult_start(mult_start), .div_start(div_start),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit signed arithmetic; SV division truncates toward zero
    // and % takes the dividend's sign, which is exactly the required result.
    task automatic model(input bit mul, input logic [31:0] a, input logic [31:0] b);
        longint p, q, r;
        if (mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            exp_hi = p[63:32]; exp_lo = p[31:0]; exp_dbz = 1'b0; exp_lat = 33;
        end else if (b == 0) begin
            exp_dbz = 1'b1; exp_lat = 1;
        end else begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            exp_hi = r[31:0]; exp_lo = q[31:0]; exp_dbz = 1'b0; exp_lat = 33;
        end
    endtask

    // Call at a negedge; returns at the negedge of the done cycle.
    task automatic do_op(input bit mul, input bit dv, input logic [31:0] a,
                         input logic [31:0] b, input bit poke);
        int lat, bc;
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        mult_start = mul; div_start = dv; op_a = a; op_b = b;
        model(mul, a, b);
        @(posedge clk);
        @(negedge clk);
        mult_start = 0; div_start = 0; op_a = $urandom; op_b = $urandom;
        chk("hold_hi", hi, h0);
        chk("hold_lo", lo, l0);
        chk("dbz_at_accept", div_by_zero, exp_dbz);
        lat = 0; bc = 0;
        while (!done && lat < 200) begin
            if (busy) bc++;
            if (poke && lat == 10) begin
                div_start = 1; op_a = 32'd9; op_b = 32'd0;
            end else div_start = 0;
            @(negedge clk);
            lat++;
        end
        div_start = 0;
        chk("latency", lat, exp_lat);
        chk("busy_cycles", bc, exp_lat);
        chk("busy_at_done", busy, 0);
        chk("hi", hi, exp_hi);
        chk("lo", lo, exp_lo);
        chk("div_by_zero", div_by_zero, exp_dbz);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int nd;
        bit mul, b2b;
        logic [31:0] a, b;

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        @(negedge clk) reset_n = 1;
        @(negedge clk);

        // T1 / T2
        do_op(1, 0, 32'd7, -32'sd3, 0);
        chk("t1_hi", hi, 32'hFFFFFFFF);
        chk("t1_lo", lo, 32'hFFFFFFEB);
        @(negedge clk) chk("done_one_cycle", done, 0);
        do_op(1, 0, 32'h80000000, 32'h80000000, 0);
        chk("t2a_hi", hi, 32'h40000000);
        chk("t2a_lo", lo, 32'h00000000);
        @(negedge clk);
        do_op(1, 0, 32'hFFFFFFFF, 32'd1, 0);
        chk("t2b_hi", hi, 32'hFFFFFFFF);
        chk("t2b_lo", lo, 32'hFFFFFFFF);

        // T3
        @(negedge clk);
        do_op(0, 1, -32'sd7, 32'd2, 0);
        chk("t3a_hi", hi, 32'hFFFFFFFF);
        chk("t3a_lo", lo, 32'hFFFFFFFD);
        @(negedge clk);
        do_op(0, 1, 32'd7, -32'sd2, 0);
        chk("t3b_hi", hi, 32'h00000001);
        chk("t3b_lo", lo, 32'hFFFFFFFD);
        @(negedge clk);
        do_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("t3c_hi", hi, 32'h00000000);
        chk("t3c_lo", lo, 32'h80000000);

        // T4: preload, divide by zero, then clear on next accept
        @(negedge clk);
        do_op(1, 0, 32'h12345678, 32'h9ABCDEF0, 0);
        @(negedge clk);
        do_op(0, 1, 32'd5, 32'd0, 0);
        @(negedge clk);
        do_op(0, 1, 32'd100, 32'd7, 0);

        // T5: both starts -> MULT; poke while busy -> ignored; back-to-back
        @(negedge clk);
        do_op(1, 1, 32'd1000, 32'd3, 0);
        chk("t5_both_lo", lo, 32'd3000);
        @(negedge clk);
        do_op(1, 0, 32'hFFFF0000, 32'h00012345, 1);
        count_done(40, nd);
        chk("t5_single_done", nd, 0);
        chk("t5_poke_dbz", div_by_zero, 0);
        do_op(1, 0, 32'd6, 32'd7, 0);
        do_op(0, 1, -32'sd100, 32'd9, 0);

        // T6: async reset mid-multiply
        @(negedge clk);
        mult_start = 1; op_a = 32'hDEADBEEF; op_b = 32'h0BADF00D;
        @(posedge clk);
        @(negedge clk) mult_start = 0;
        repeat (9) @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_hi", hi, 0);
        chk("t6_lo", lo, 0);
        exp_hi = '0; exp_lo = '0; exp_dbz = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        count_done(40, nd);
        chk("t6_no_done", nd, 0);
        do_op(1, 0, 32'hFFFFFFF0, 32'h00000010, 0);

        // Randomized mix, sometimes issued in the done cycle
        for (int i = 0; i < 40; i++) begin
            mul = ($urandom_range(0, 1) == 1);
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h80000000;
                2: b = 32'hFFFFFFFF;
                3: b = $urandom_range(1, 15);
                default: ;
            endcase
            b2b = ($urandom_range(0, 1) == 1);
            if (!b2b) @(negedge clk) chk("rnd_done_low", done, 0);
            do_op(mul, !mul, a, b, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
